// File: rtl/bcd_display_scanner_pkg.sv
// rtl/bcd_display_scanner_pkg.sv - shared constants for the display scanner and its decoder
package bcd_display_scanner_pkg;

  localparam int DEFAULT_NUM_DIGITS  = 4;
  localparam int DEFAULT_REFRESH_DIV = 1000;
  localparam int MAX_DIGITS          = 8;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] BCD_BLANK = 4'd0;

  // Wide enough for the largest display; users slice off NUM_DIGITS bits.
  localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;

endpackage

// File: rtl/display_tick_gen.sv
// rtl/display_tick_gen.sv - free-running prescaler producing a one-cycle tick every DIV clocks
module display_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed BCD digit scanner with frame latch and blanking
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    bcd_err,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] OFF = DIGIT_OFF[NUM_DIGITS-1:0];

  logic                    tick;
  logic                    tick_d;
  logic                    load_pending;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] view;
  logic [3:0]              cur;
  logic                    cur_lz;
  logic                    lz_run;
  logic                    blanked;
  logic [NUM_DIGITS-1:0]   en_n;

  display_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      shadow       <= '0;
      load_pending <= 1'b1;
      tick_d       <= 1'b0;
    end else begin
      load_pending <= 1'b0;
      tick_d       <= tick;
      if (tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      if (load_pending || (tick && idx == LAST_IDX)) begin
        shadow <= digits_in;
      end
    end
  end

  // The first slot after reset reads the word being latched on that same edge,
  // so the opening frame never shows the cleared shadow.
  assign view = load_pending ? digits_in : shadow;

  always_comb begin
    cur    = BCD_BLANK;
    cur_lz = 1'b0;
    lz_run = 1'b1;
    en_n   = OFF;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (view[4*i +: 4] == 4'd0);
      if (IDX_W'(i) == idx) begin
        cur     = view[4*i +: 4];
        cur_lz  = lz_run && (i != 0);
        en_n[i] = 1'b0;
      end
    end
    blanked = (blank_lz && cur_lz) || (cur > BCD_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_out     <= BCD_BLANK;
      digit_en_n  <= OFF;
      bcd_err     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      bcd_out     <= blanked ? BCD_BLANK : cur;
      digit_en_n  <= blanked ? OFF : en_n;
      bcd_err     <= (cur > BCD_MAX);
      frame_start <= (load_pending || tick_d) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - randomized self-checking bench for the display scanner
module tb_bcd_display_scanner;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en_n;
  logic        bcd_err;
  logic        frame_start;

  int          vectors = 0;
  int          miscompares = 0;
  int          t = 0;
  logic [15:0] latched = 16'h0000;
  logic [15:0] pending = 16'h0000;
  logic [9:0]  exp_out;
  logic [9:0]  got;

  bcd_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .blank_lz    (blank_lz),
    .bcd_out     (bcd_out),
    .digit_en_n  (digit_en_n),
    .bcd_err     (bcd_err),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Expected {bcd_out, digit_en_n, bcd_err, frame_start} for digit slot s of value v.
  function automatic logic [9:0] expect_out(logic [15:0] v, int s, logic blz, logic fs);
    logic [15:0] upper;
    logic [3:0]  d;
    logic [3:0]  one_hot;
    logic        blanked;
    upper   = v >> (4 * s);
    d       = upper[3:0];
    one_hot = 4'b0001 << s;
    blanked = (blz && s != 0 && upper == 16'h0000) || (d > 4'd9);
    return {blanked ? 4'd0 : d, blanked ? 4'hF : ~one_hot, d > 4'd9, fs};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int k = 0; k < 4; k++) begin
      w[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    return w;
  endfunction

  // Advance one clock: predict from the cycle count since release, then sample #1 after the edge.
  task automatic cycle();
    if (rst) begin
      exp_out = {4'd0, 4'hF, 1'b0, 1'b0};
    end else begin
      if (t == 0) latched = digits_in;
      else if (t % FRAME == 0) latched = pending;
      if (t % FRAME == FRAME - 1) pending = digits_in;
      exp_out = expect_out(latched, (t / DIV) % N, blank_lz, (t % FRAME) == 0);
    end
    @(posedge clk);
    #1;
    t = rst ? 0 : t + 1;
    got = {bcd_out, digit_en_n, bcd_err, frame_start};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL reset t=%0d got=%h exp=%h", t, got, exp_out);
      end
    end
  endtask

  task automatic run_fixed(string name, logic [15:0] val, logic blz, int n);
    digits_in = val;
    blank_lz  = blz;
    rst       = 1'b0;
    for (int i = 0; i < n; i++) begin
      cycle();
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp_out);
      end
    end
  endtask

  task automatic test_scan();
    run_fixed("scan_1234", 16'h1234, 1'b0, 3 * FRAME);
  endtask

  task automatic test_blanking();
    run_fixed("blank_0045_lz", 16'h0045, 1'b1, 2 * FRAME);
    run_fixed("blank_0045_nolz", 16'h0045, 1'b0, 2 * FRAME);
    run_fixed("blank_0000_lz", 16'h0000, 1'b1, 2 * FRAME);
  endtask

  task automatic test_bcd_err();
    run_fixed("err_12a4", 16'h12A4, 1'b0, 2 * FRAME);
    run_fixed("err_12a4_lz", 16'h0FA0, 1'b1, 2 * FRAME);
  endtask

  task automatic test_mid_frame();
    int guard;
    digits_in = 16'h1234;
    blank_lz  = 1'b0;
    guard     = 0;
    while ((t % FRAME) != 2 * DIV + 2 && guard < 4 * FRAME) begin
      cycle();
      guard++;
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL mid_pre t=%0d got=%h exp=%h", t, got, exp_out);
      end
    end
    vectors++;
    if (guard >= 4 * FRAME) begin
      miscompares++;
      $display("FAIL mid_align t=%0d got=%0d exp=<%0d", t, guard, 4 * FRAME);
    end
    digits_in = 16'h5678;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle();
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL mid_post t=%0d got=%h exp=%h", t, got, exp_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while ((t % FRAME) != 2 * DIV + 1 && guard < 4 * FRAME) begin
      cycle();
      guard++;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL rst_mid t=%0d got=%h exp=%h", t, got, exp_out);
      end
    end
    digits_in = 16'h9081;
    run_fixed("rst_restart", 16'h9081, 1'b1, 2 * FRAME);
  endtask

  task automatic test_random();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) digits_in = rand_word();
      if ($urandom_range(0, 9) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 150) == 0) rst = 1'b1;
      else rst = 1'b0;
      cycle();
      vectors++;
      if (got !== exp_out) begin
        miscompares++;
        $display("FAIL random t=%0d in=%h got=%h exp=%h", t, digits_in, got, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_bcd_err();
    test_mid_frame();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Time-multiplexed driver for a multi-digit seven-segment display. It sits directly upstream of the BCD-to-seven-segment decoder. Each refresh slot it selects one BCD digit from a packed input word, presents that digit's 4-bit code to the decoder and drives the matching active-low digit enable. It also provides frame-coherent input sampling, leading-zero blanking and invalid-code suppression.

Parameters:
NUM_DIGITS, 4, number of display digits; legal range 2..8.
REFRESH_DIV, 1000, clock cycles each digit stays lit; must be >= 2.
CNT_W, $clog2(REFRESH_DIV), prescaler width; derived, not overridden.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
digits_in  in  4*NUM_DIGITS  packed BCD value; digit 0 (least significant) in bits [3:0]
blank_lz  in  1  1 = blank leading zeros
bcd_out  out  4  BCD code to the seven-segment decoder
digit_en_n  out  NUM_DIGITS  active-low digit enables, at most one low
bcd_err  out  1  high while the current slot holds a code > 9
frame_start  out  1  one-cycle pulse when digit 0 begins a new frame

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset is synchronous and active-high, rst.

Reset (rst=1 at a rising edge):
- prescaler=0, idx=0, shadow=0, load_pending=1.
- bcd_out=4'd0, digit_en_n=all 1s, bcd_err=0, frame_start=0.
- rst mid-frame aborts the scan immediately; no partial outputs persist.

Prescaler:
- Counts 0..REFRESH_DIV-1 and wraps.
- tick=1 when count==REFRESH_DIV-1.

Digit index:
- idx advances on tick.
- Wraps NUM_DIGITS-1 -> 0.

Frame latch:
- shadow <= digits_in on the first edge with rst=0 after reset (load_pending), and on every tick where idx wraps to 0.
- digits_in changes between loads have no effect on the display.

Blanking, combinational on shadow:
- Scanning from digit NUM_DIGITS-1 downward, a digit is leading-zero if it and every higher digit equal 0.
- Digit 0 is never leading-zero, so value 0 shows a single "0".
- A digit is blanked if (blank_lz and leading-zero) or its code > 9.

Output register, 1-cycle latency from idx/shadow:
- bcd_out = blanked ? 0 : shadow[idx].
- digit_en_n = blanked ? all 1s : ~(1<<idx).
- bcd_err = (shadow[idx] > 9).
- frame_start = 1 for exactly one cycle: the first output cycle showing idx 0 of each frame, including the first frame after reset.

Timing:
- Each digit's outputs hold for exactly REFRESH_DIV cycles.
- Full frame = NUM_DIGITS*REFRESH_DIV cycles.

Simultaneous events:
- A wrap tick and a shadow load on the same edge: the new shadow is used for the idx-0 slot.
- rst wins over everything.

Decomposition:
- Shared package: default NUM_DIGITS, BCD_MAX=4'd9, BCD_BLANK=4'd0, DIGIT_OFF constant (all 1s). The decoder also reuses BCD_MAX.
- Sub-module: display_tick_gen (parameter DIV; ports clk, rst, tick). It is reusable for debounce and blink timing.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
1. Reset then release; digits_in=16'h1234, blank_lz=0 -> frame_start pulses once. Then bcd_out sequence 4,3,2,1 with digit_en_n 1110,1101,1011,0111, each held 4 cycles, repeating every 16 cycles.
2. digits_in=16'h0045, blank_lz=1 -> slots 2 and 3 have digit_en_n=1111 and bcd_out=0; slots 0 and 1 show 5 and 4. With blank_lz=0 all four slots are lit and show 5,4,0,0.
3. digits_in=16'h0000, blank_lz=1 -> only digit 0 lit with bcd_out=0; the other three slots are all-off.
4. digits_in=16'h12A4 -> the slot-1 output shows bcd_err=1, digit_en_n=1111 and bcd_out=0. The other slots show 4, 2, 1 normally with bcd_err=0.
5. Change digits_in from 16'h1234 to 16'h5678 in the middle of the slot-2 output -> the remaining slots still show 2,1. The next frame shows 8,7,6,5.
6. Assert rst during the slot-2 output -> the next cycle has all outputs at reset values. After release, scanning restarts at digit 0 with a fresh frame_start pulse.
